// File: rtl/exe_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
// Latency: XLEN+1 cycles for iterative multiply and divide, 1 cycle for divide special cases and the single-cycle multiplier.
// Backpressure: stall_req_out holds the upstream stages until the DONE cycle; flush_in kills the operation with no write-back.
module exe_muldiv #(
    parameter int XLEN          = 32,
    parameter int RADDR_WIDTH   = 5,
    parameter int MUL_ITERATIVE = 1
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic [2:0]             funct3_in,
    input  logic [XLEN-1:0]        op1_in,
    input  logic [XLEN-1:0]        op2_in,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_in,
    input  logic                   flush_in,
    output logic                   stall_req_out,
    output logic                   busy_out,
    output logic                   result_valid_out,
    output logic [XLEN-1:0]        result_out,
    output logic [RADDR_WIDTH-1:0] reg_waddr_out,
    output logic                   reg_we_out
);

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [2:0]             funct3_q;
    logic [RADDR_WIDTH-1:0] waddr_q;
    logic [XLEN-1:0]        b_q;        // |op2|: multiplicand or divisor
    logic [2*XLEN-1:0]      acc_q;      // product accumulator, or {remainder, quotient}
    logic                   neg_q;      // final result must be negated
    logic [CW-1:0]          cnt_q;
    logic [XLEN-1:0]        result_q;
    logic                   valid_q;

    // Start-cycle decode: operand magnitudes, result sign and the one-cycle shortcuts
    logic              is_div_in, sgn1_in, sgn2_in, s1_in, s2_in, neg_in;
    logic              div_zero_in, ovf_in;
    logic [XLEN-1:0]   a_abs, b_abs, special_res, fast_res;
    logic [2*XLEN-1:0] fast_prod, fast_fix;

    // Classify the incoming operation and precompute results that need no iteration
    always_comb begin
        is_div_in   = funct3_in[2];
        // op1 is signed for MULH, MULHSU, DIV, REM; op2 for MULH, DIV, REM
        sgn1_in     = funct3_in[2] ? ~funct3_in[0] : (funct3_in[1] ^ funct3_in[0]);
        sgn2_in     = funct3_in[2] ? ~funct3_in[0] : (funct3_in[1:0] == 2'b01);
        s1_in       = sgn1_in & op1_in[XLEN-1];
        s2_in       = sgn2_in & op2_in[XLEN-1];
        a_abs       = s1_in ? -op1_in : op1_in;
        b_abs       = s2_in ? -op2_in : op2_in;
        // Remainder takes the dividend's sign; products and quotients the XOR
        neg_in      = (is_div_in & funct3_in[1]) ? s1_in : (s1_in ^ s2_in);
        div_zero_in = is_div_in & (op2_in == '0);
        ovf_in      = is_div_in & ~funct3_in[0] & (op1_in == MIN_NEG) & (op2_in == '1);
        if (div_zero_in) begin
            special_res = funct3_in[1] ? op1_in : '1;
        end else begin
            special_res = funct3_in[1] ? '0 : op1_in;
        end
        fast_prod = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
        fast_fix  = neg_in ? -fast_prod : fast_prod;
        fast_res  = (funct3_in[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
    end

    // One iteration step for each engine and the sign-corrected final result
    logic [XLEN:0]     mul_sum, r_sh, diff;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next, mul_p;
    logic [XLEN-1:0]   mul_res, div_sel, div_res, final_res;

    // Shift-add multiply and restoring divide share the accumulator layout
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        r_sh     = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = r_sh - {1'b0, b_q};
        // A borrow means the divisor did not fit: keep the shifted remainder
        if (diff[XLEN]) begin
            div_next = {r_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
        iter_next = funct3_q[2] ? div_next : mul_next;
        // Negate the full double-width product before picking a half
        mul_p     = neg_q ? -iter_next : iter_next;
        mul_res   = (funct3_q[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
        div_sel   = funct3_q[1] ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
        div_res   = neg_q ? -div_sel : div_sel;
        final_res = funct3_q[2] ? div_res : mul_res;
    end

    // Control FSM with registered result, write-back address and valid
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            waddr_q  <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_in && !flush_in) begin
                        funct3_q <= funct3_in;
                        waddr_q  <= reg_waddr_in;
                        b_q      <= b_abs;
                        acc_q    <= {{XLEN{1'b0}}, a_abs};
                        neg_q    <= neg_in;
                        cnt_q    <= CW'(XLEN - 1);
                        if (div_zero_in || ovf_in) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (!is_div_in && (MUL_ITERATIVE == 0)) begin
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (flush_in) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= iter_next;
                        if (cnt_q == '0) begin
                            result_q <= final_res;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // A flush in the DONE cycle still suppresses the write-back
    assign result_valid_out = valid_q & ~flush_in;
    assign reg_we_out       = valid_q & ~flush_in;
    assign result_out       = result_q;
    assign reg_waddr_out    = waddr_q;
    assign busy_out         = (state_q != S_IDLE);
    assign stall_req_out    = reset_in & start_in & (state_q != S_DONE) & ~flush_in;

endmodule

// File: tb/tb_exe_muldiv.sv
module tb_exe_muldiv;

    localparam int XL = 32;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        start, flush;
    logic [2:0]  f3;
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    bit          sel_fast;

    logic        start_i, start_f;
    logic        stall_i, busy_i, vld_i, we_i;
    logic        stall_f, busy_f, vld_f, we_f;
    logic [31:0] res_i, res_f;
    logic [4:0]  wa_i, wa_f;
    logic        stall, busy, vld, we;
    logic [31:0] res;
    logic [4:0]  wa;

    assign start_i = start & ~sel_fast;
    assign start_f = start & sel_fast;
    assign stall   = sel_fast ? stall_f : stall_i;
    assign busy    = sel_fast ? busy_f  : busy_i;
    assign vld     = sel_fast ? vld_f   : vld_i;
    assign we      = sel_fast ? we_f    : we_i;
    assign res     = sel_fast ? res_f   : res_i;
    assign wa      = sel_fast ? wa_f    : wa_i;

    exe_muldiv #(.XLEN(XL), .RADDR_WIDTH(5), .MUL_ITERATIVE(1)) dut_iter (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_i), .funct3_in(f3),
        .op1_in(op1), .op2_in(op2), .reg_waddr_in(rd), .flush_in(flush),
        .stall_req_out(stall_i), .busy_out(busy_i), .result_valid_out(vld_i),
        .result_out(res_i), .reg_waddr_out(wa_i), .reg_we_out(we_i)
    );

    exe_muldiv #(.XLEN(XL), .RADDR_WIDTH(5), .MUL_ITERATIVE(0)) dut_fast (
        .clk_in(clk_in), .reset_in(reset_in), .start_in(start_f), .funct3_in(f3),
        .op1_in(op1), .op2_in(op2), .reg_waddr_in(rd), .flush_in(flush),
        .stall_req_out(stall_f), .busy_out(busy_f), .result_valid_out(vld_f),
        .result_out(res_f), .reg_waddr_out(wa_f), .reg_we_out(we_f)
    );

    always #5 clk_in = ~clk_in;

    int gcyc = 0;
    always @(posedge clk_in) gcyc <= gcyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, gcyc);
        end
    endtask

    // Architectural reference: plain wide arithmetic plus the RISC-V M special cases
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        model = '0;
        case (f)
            3'b000: begin p = ua * ub; model = p[31:0]; end
            3'b001: begin p = sa * sb; model = p[63:32]; end
            3'b010: begin p = sa * longint'(ub); model = p[63:32]; end
            3'b011: begin p = ua * ub; model = p[63:32]; end
            3'b100: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = a;
                else begin q = sa / sb; model = q[31:0]; end
            end
            3'b101: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = '0;
                else begin q = sa % sb; model = q[31:0]; end
            end
            default: model = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected timeline of the operation currently in flight
    bit          exp_on = 1'b0;
    int          exp_t0 = 0;
    int          exp_lat = 0;
    int          exp_kill = -1;
    logic [31:0] exp_res = '0;
    logic [4:0]  exp_rd = '0;
    bit          mon_en = 1'b0;
    int          mk;
    bit          mfire, mbusy;

    // Compare process: every falling edge, all outputs against the timeline
    always @(negedge clk_in) begin
        if (mon_en) begin
            if (!reset_in) begin
                check("rst_stall", stall, 0);
                check("rst_busy", busy, 0);
                check("rst_valid", vld, 0);
                check("rst_we", we, 0);
                check("rst_result", res, 0);
                check("rst_waddr", wa, 0);
            end else begin
                mk    = gcyc - exp_t0;
                mfire = exp_on && (exp_kill < 0) && (mk == exp_lat);
                mbusy = exp_on && (mk >= 1) && (mk <= exp_lat) && ((exp_kill < 0) || (mk <= exp_kill));
                check("valid", vld, mfire);
                check("we", we, mfire);
                check("busy", busy, mbusy);
                check("stall", stall, start & ~flush & ~mfire);
                if (mfire) begin
                    check("result", res, exp_res);
                    check("waddr", wa, exp_rd);
                end
            end
        end
    end

    // Issue one M instruction, holding it while stalled; optional flush at cycle flushk
    task automatic run_op(input bit fast, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int flushk, input bit chk,
                          input logic [31:0] lit, input int lit_lat, input string nm);
        int k;
        bit done;
        @(posedge clk_in);
        #1;
        sel_fast = fast;
        start    = 1'b1;
        flush    = (flushk == 0);
        f3       = f;
        op1      = a;
        op2      = b;
        rd       = d;
        exp_on   = 1'b1;
        exp_t0   = gcyc;
        exp_kill = flushk;
        exp_res  = model(f, a, b);
        exp_rd   = d;
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) exp_lat = 1;
        else if (!f[2] && fast) exp_lat = 1;
        else exp_lat = XL + 1;
        k    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk_in);
            if (!stall) begin
                done = 1'b1;
            end else if (k >= 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_timeout: stall still high after %0d cycles, required to drop", nm, k);
                done = 1'b1;
            end else begin
                @(posedge clk_in);
                #1;
                k++;
                if (k == flushk) flush = 1'b1;
            end
        end
        if (chk) begin
            check({nm, "_lat"}, k, lit_lat);
            check({nm, "_res"}, res, lit);
            check({nm, "_vld"}, vld, 1);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk_in);
        #1;
        start = 1'b0;
        flush = 1'b0;
        repeat (n - 1) @(posedge clk_in);
    endtask

    // Reset asserted in the middle of a DIV at cycle 15
    task automatic reset_mid();
        @(posedge clk_in);
        #1;
        sel_fast = 1'b0;
        start    = 1'b1;
        flush    = 1'b0;
        f3       = 3'b100;
        op1      = 32'hFFFF_FFF9;
        op2      = 32'd2;
        rd       = 5'd7;
        exp_on   = 1'b1;
        exp_t0   = gcyc;
        exp_kill = -1;
        exp_res  = model(3'b100, op1, op2);
        exp_rd   = 5'd7;
        exp_lat  = XL + 1;
        repeat (15) begin
            @(posedge clk_in);
            #1;
        end
        #2;
        reset_in = 1'b0;
        exp_on   = 1'b0;
        #1;
        check("arst_busy", busy_i, 0);
        check("arst_stall", stall_i, 0);
        check("arst_valid", vld_i, 0);
        check("arst_we", we_i, 0);
        check("arst_result", res_i, 0);
        check("arst_waddr", wa_i, 0);
        repeat (2) @(posedge clk_in);
        #1;
        start = 1'b0;
        #1;
        reset_in = 1'b1;
    endtask

    initial begin
        reset_in = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        f3       = '0;
        op1      = '0;
        op2      = '0;
        rd       = '0;
        sel_fast = 1'b0;
        mon_en   = 1'b1;
        repeat (2) @(posedge clk_in);
        #2;
        check("init_busy", busy_i, 0);
        check("init_result", res_i, 0);
        check("init_fast_valid", vld_f, 0);
        @(posedge clk_in);
        #1;
        reset_in = 1'b1;

        // Iterative multiplier
        run_op(0, 3'b000, 32'd7,          32'hFFFF_FFFD, 5'd1, -1, 1, 32'hFFFF_FFEB, 33, "mul");
        run_op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, -1, 1, 32'h4000_0000, 33, "mulh");
        run_op(0, 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd3, -1, 1, 32'hC000_0000, 33, "mulhsu");
        run_op(0, 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd4, -1, 1, 32'h4000_0000, 33, "mulhu");
        run_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, -1, 1, 32'hFFFF_FFFE, 33, "mulhu_max");
        run_op(0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, -1, 1, 32'h0000_0000, 33, "mulh_m1");
        // Single-cycle multiplier
        run_op(1, 3'b000, 32'd7,          32'hFFFF_FFFD, 5'd8, -1, 1, 32'hFFFF_FFEB, 1, "fmul");
        run_op(1, 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd9, -1, 1, 32'h4000_0000, 1, "fmulh");
        run_op(1, 3'b010, 32'h8000_0000, 32'h8000_0000, 5'd10, -1, 1, 32'hC000_0000, 1, "fmulhsu");
        run_op(1, 3'b011, 32'h8000_0000, 32'h8000_0000, 5'd11, -1, 1, 32'h4000_0000, 1, "fmulhu");
        // Divider, normal cases
        run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2,          5'd12, -1, 1, 32'hFFFF_FFFD, 33, "div");
        run_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2,          5'd13, -1, 1, 32'hFFFF_FFFF, 33, "rem");
        run_op(0, 3'b101, 32'hFFFF_FFF9, 32'd2,          5'd14, -1, 1, 32'h7FFF_FFFC, 33, "divu");
        run_op(0, 3'b111, 32'hFFFF_FFF9, 32'd2,          5'd15, -1, 1, 32'h0000_0001, 33, "remu");
        run_op(0, 3'b100, 32'd100,        32'hFFFF_FFF9, 5'd16, -1, 1, 32'hFFFF_FFF2, 33, "div_negdiv");
        run_op(0, 3'b110, 32'd100,        32'hFFFF_FFF9, 5'd17, -1, 1, 32'h0000_0002, 33, "rem_negdiv");
        run_op(0, 3'b110, 32'd7,          32'h8000_0000, 5'd18, -1, 1, 32'h0000_0007, 33, "rem_mindiv");
        // Divider special cases
        run_op(0, 3'b100, 32'd5,          32'd0,         5'd19, -1, 1, 32'hFFFF_FFFF, 1, "div0");
        run_op(0, 3'b110, 32'd5,          32'd0,         5'd20, -1, 1, 32'h0000_0005, 1, "rem0");
        run_op(0, 3'b101, 32'd5,          32'd0,         5'd21, -1, 1, 32'hFFFF_FFFF, 1, "divu0");
        run_op(0, 3'b111, 32'd5,          32'd0,         5'd22, -1, 1, 32'h0000_0005, 1, "remu0");
        run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, -1, 1, 32'h8000_0000, 1, "div_ovf");
        run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd24, -1, 1, 32'h0000_0000, 1, "rem_ovf");
        run_op(0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd25, -1, 1, 32'h0000_0000, 33, "divu_noovf");
        // Flush at cycle 10, then a MUL issued immediately
        run_op(0, 3'b100, 32'd100,        32'd7,         5'd26, 10, 0, 32'd0, 0, "div_flush");
        run_op(0, 3'b000, 32'd7,          32'hFFFF_FFFD, 5'd27, -1, 1, 32'hFFFF_FFEB, 33, "mul_after_flush");
        // Start and flush in the same cycle
        run_op(0, 3'b100, 32'd100,        32'd7,         5'd28, 0, 0, 32'd0, 0, "start_flush");
        idle(2);
        #2;
        check("start_flush_busy", busy_i, 0);
        check("start_flush_valid", vld_i, 0);
        // Asynchronous reset mid-divide, then a clean divide
        reset_mid();
        run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2,          5'd29, -1, 1, 32'hFFFF_FFFD, 33, "div_after_rst");
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
